// File: rtl/char_console.sv
`default_nettype none
// ============================================================================
// Module      : char_console
// Description : Byte-stream text writer for the 80x50 character display. It
//               tracks the cursor, interprets CR/LF/BS/FF and issues VRAM
//               writes. Optional macro CHAR_CONSOLE_LINECLR_EN blanks each new
//               row on entry.
// Revision    : 1.0 - initial release
// ============================================================================
module char_console #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 50,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CH_VALID,
  input  logic [7:0]  CH_DATA,
  output logic        CH_READY,
  input  logic [2:0]  COLOR,
  output logic [15:0] WRADDR,
  output logic [3:0]  BYTEEN,
  output logic        WREN,
  output logic [31:0] WRDATA,
  output logic [6:0]  CUR_COL,
  output logic [5:0]  CUR_ROW,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PUT     = 2'd1,
    S_CLRSCR  = 2'd2,
    S_CLRLINE = 2'd3
  } state_t;

  localparam logic [7:0]  c_cr       = 8'h0D;
  localparam logic [7:0]  c_lf       = 8'h0A;
  localparam logic [7:0]  c_bs       = 8'h08;
  localparam logic [7:0]  c_ff       = 8'h0C;
  localparam logic [11:0] c_last_cell = 12'(COLS * ROWS - 1);
  localparam logic [11:0] c_last_col  = 12'(COLS - 1);

  // Where PUT goes after any row change: line clear only in the optional build.
`ifdef CHAR_CONSOLE_LINECLR_EN
  localparam state_t c_after_row = S_CLRLINE;
`else
  localparam state_t c_after_row = S_IDLE;
`endif

  state_t      r_state, w_state_nxt;
  logic        r_live;
  logic [7:0]  r_code;
  logic [2:0]  r_color;
  logic [6:0]  r_col, w_col_nxt;
  logic [5:0]  r_row, w_row_nxt;
  logic [11:0] r_cnt, w_cnt_nxt;
  logic [11:0] w_base, w_cell;
  logic [5:0]  w_row_inc;
  logic        w_wren;
  logic [7:0]  w_wr_code;
  logic        w_accept;

  // row*80 as (row<<6)+(row<<4); 12 bits hold the largest cell index 3999.
  assign w_base    = (12'(r_row) << 6) + (12'(r_row) << 4);
  assign w_row_inc = (r_row == 6'(ROWS - 1)) ? 6'd0 : r_row + 6'd1;
  assign CH_READY  = r_live && (r_state == S_IDLE);
  assign w_accept  = CH_VALID && CH_READY;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_wren      = 1'b0;
    w_cell      = 12'd0;
    w_wr_code   = r_code;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = 12'd0;
          w_state_nxt = (CH_DATA == c_ff) ? S_CLRSCR : S_PUT;
        end
      end
      S_PUT: begin
        w_state_nxt = S_IDLE;
        case (r_code)
          c_cr: w_col_nxt = 7'd0;
          c_lf: begin
            w_col_nxt   = 7'd0;
            w_row_nxt   = w_row_inc;
            w_state_nxt = c_after_row;
          end
          c_bs: begin
            if (r_col != 7'd0) w_col_nxt = r_col - 7'd1;
          end
          default: begin
            w_wren = 1'b1;
            w_cell = w_base + 12'(r_col);
            if (r_col == 7'(COLS - 1)) begin
              w_col_nxt   = 7'd0;
              w_row_nxt   = w_row_inc;
              w_state_nxt = c_after_row;
            end else begin
              w_col_nxt = r_col + 7'd1;
            end
          end
        endcase
      end
      S_CLRSCR: begin
        w_wren    = 1'b1;
        w_cell    = r_cnt;
        w_wr_code = CLEAR_CHAR;
        if (r_cnt == c_last_cell) begin
          w_cnt_nxt   = 12'd0;
          w_col_nxt   = 7'd0;
          w_row_nxt   = 6'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 12'd1;
        end
      end
      S_CLRLINE: begin
        // Cursor already points at the new row, so it supplies the base.
        w_wren    = 1'b1;
        w_cell    = w_base + r_cnt;
        w_wr_code = CLEAR_CHAR;
        if (r_cnt == c_last_col) begin
          w_cnt_nxt   = 12'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 12'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_code  <= 8'h00;
      r_color <= 3'b000;
      r_col   <= 7'd0;
      r_row   <= 6'd0;
      r_cnt   <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_code  <= CH_DATA;
        r_color <= COLOR;
      end
    end
  end

  assign WREN    = w_wren;
  assign BYTEEN  = w_wren ? 4'hf : 4'h0;
  assign WRADDR  = w_wren ? {2'b00, w_cell, 2'b00} : 16'h0000;
  assign WRDATA  = w_wren ? {21'b0, r_color, w_wr_code} : 32'h0000_0000;
  assign CUR_COL = r_col;
  assign CUR_ROW = r_row;
  assign BUSY    = (r_state == S_CLRSCR) || (r_state == S_CLRLINE);

endmodule
`default_nettype wire

// File: doc/char_console.md
# char_console

Stream-to-VRAM text writer for the character display. Accepts a byte stream of character codes over a valid/ready handshake, tracks a cursor on the 80x50 text screen, and issues single-cycle writes on the display's VRAM write port (WRADDR/BYTEEN/WREN/WRDATA). It also interprets control codes and provides a hardware screen clear, so a CPU or UART front end can drive the display with plain text.

## Interface
- COLS, 80: characters per row.
- ROWS, 50: rows per screen.
- CLEAR_CHAR, 8'h20: code written by clear operations.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- CH_VALID  in  1  CH_DATA valid.
- CH_DATA  in  8  character or control code.
- CH_READY  out  1  block can accept a byte this cycle.
- COLOR  in  3  {R,G,B} attribute, sampled with each accepted byte.
- WRADDR  out  16  VRAM byte address = cell index << 2.
- BYTEEN  out  4  always 4'hf when WREN=1, else 4'h0.
- WREN  out  1  one-cycle VRAM write strobe.
- WRDATA  out  32  {21'b0, color[2:0], code[7:0]}.
- CUR_COL  out  7  cursor column, 0..COLS-1.
- CUR_ROW  out  6  cursor row, 0..ROWS-1.
- BUSY  out  1  clear in progress.

## Operation
- States: IDLE, PUT, CLRSCR, CLRLINE.
- IDLE: CH_READY=1. A byte is accepted on a rising edge with CH_VALID=1 and CH_READY=1. The block latches CH_DATA and COLOR and moves to PUT, or to CLRSCR for 8'h0C.
- PUT handles one accepted byte in one cycle:
  - 8'h0D (CR): col=0.
  - 8'h0A (LF): col=0, row=row+1.
  - 8'h08 (BS): col=col-1 when col>0; no-op at col 0.
  - Any other code: WREN=1, WRADDR=(row*COLS+col)<<2, WRDATA={21'b0,color,code}. Then col=col+1. At col=COLS-1, col=0 and row=row+1.
  - Control codes never assert WREN.
- Row increment past ROWS-1 wraps to row 0. There is no scrolling.
- CLRSCR (8'h0C, FF): writes CLEAR_CHAR with the latched color to cells 0..COLS*ROWS-1 in ascending order, one write per cycle with no gaps. Then cursor=(0,0) and the block returns to IDLE. BUSY=1 throughout.
- Address arithmetic: row*80 is computed as (row<<6)+(row<<4). The cell index is at most 3999, so the byte address is at most 16'h3E7C. No truncation is permitted.

## Timing
- Reset (RST=0 at an edge): WREN=0, BYTEEN=0, WRADDR=0, WRDATA=0, CH_READY=0, BUSY=0, CUR_COL=0, CUR_ROW=0, state IDLE. CH_READY rises on the first edge after RST returns high.
- Accept at edge N. WREN is high for the cycle between edges N and N+1. The write is sampled by the VRAM at edge N+1. CH_READY=0 in that cycle and returns to 1 after edge N+1. Sustained throughput is 1 byte per 2 cycles.
- CUR_COL/CUR_ROW update at the edge that ends PUT and always show the position of the next write.
- Clear: the first write strobe is in the cycle after the accepting edge. The screen clear takes exactly COLS*ROWS consecutive WREN cycles; CH_READY returns on the edge after the last write.
- CH_DATA/COLOR changes while CH_READY=0 have no effect.
- Reset asserted mid-clear: the clear aborts, WREN=0 from the next cycle, and the cursor goes to (0,0). No partial state is retained.

## Configuration
- CHAR_CONSOLE_LINECLR_EN defined: whenever the row changes through LF, column wrap or row wrap, the block enters CLRLINE. CLRLINE writes CLEAR_CHAR to the COLS cells of the new row in consecutive cycles, with the color of the byte that caused the row change. CH_READY stays 0 and BUSY=1 until the line clear is done.
- CHAR_CONSOLE_LINECLR_EN undefined: row changes write nothing, and the old contents of the row remain.

## Test plan
- Reset, then send 'A' (8'h41) with COLOR=3'b100 -> exactly one WREN pulse with WRADDR=16'h0000, BYTEEN=4'hf, WRDATA=32'h0000_0441. Afterwards the cursor is (1,0).
- Send 80 printable bytes from reset -> the last write is at WRADDR=16'h013C. Afterwards CUR_COL=0, CUR_ROW=1.
- Move the cursor to (5,49), then send LF -> no write, cursor (0,0). With the macro defined, 80 writes follow at addresses 0..16'h013C.
- Send 8'h0C with COLOR=3'b111 -> 4000 consecutive WREN cycles with WRADDR 0..16'h3E7C step 4 and data 32'h0000_0720. CH_READY is low for 4000 cycles and the cursor ends at (0,0).
- At cursor (3,2), send BS, CR, BS -> no writes; the cursor goes (2,2), then (0,2), then (0,2).
- Assert RST during cycle 100 of a screen clear -> WREN=0 next cycle and no further writes. After release, CH_READY=1 and the cursor is (0,0).
